mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1: reset is synchronous and active-low; state initialises on a clk edge while reset==0.
REQ-003 Inputs PC_EX_to_Mem[31:0], RAddr1_EX_to_Mem[4:0], RegWriteAddr_EX_to_Mem[4:0], InstrType_EX_to_Mem[59:0] (one-hot), ALUOut_EX_to_Mem[31:0] (byte address or result), DMWriteData_EX_to_Mem[31:0], Tnew_WAddr_EX_to_Mem[2:0].
REQ-004 Inputs RegWriteAddr_WB[4:0], RegWriteData_WB[31:0], Tnew_WAddr_WB[2:0]: WB-stage write-back, used for store-data forwarding.
REQ-005 Registered outputs PC_Mem_to_WB[31:0], RegWriteAddr_Mem_to_WB[4:0], InstrType_Mem_to_WB[59:0], ALUOut_Mem_to_WB[31:0], DMReadData_Mem_to_WB[31:0], Tnew_WAddr_Mem_to_WB[2:0].
REQ-006 Combinational outputs to hazard unit: RegWriteAddr_Mem[4:0], Tnew_WAddr_Mem[2:0], ForwardData_Mem[31:0] (= ALUOut_EX_to_Mem).

Function
REQ-007 Data memory: 1024 x 32-bit words (4 KiB), word index ALUOut_EX_to_Mem[11:2]; bits [31:12] ignored.
REQ-008 Store data = RegWriteData_WB when RAddr1_EX_to_Mem!=0, RAddr1_EX_to_Mem==RegWriteAddr_WB, Tnew_WAddr_WB==0; else DMWriteData_EX_to_Mem.
REQ-009 sw: whole word written at clk edge; addr[1:0] ignored.
REQ-010 sh: halfword at addr[1] (0 = bits 15:0, 1 = bits 31:16) replaced by store data[15:0]; other half unchanged; addr[0] ignored.
REQ-011 sb: byte lane addr[1:0] (lane 0 = bits 7:0) replaced by store data[7:0]; other lanes unchanged.
REQ-012 Read is combinational from the array; lw word, lh/lhu select halfword by addr[1], lb/lbu select byte by addr[1:0]; lh/lb sign-extend, lhu/lbu zero-extend; result registered into DMReadData_Mem_to_WB.
REQ-013 Non-load instructions: DMReadData_Mem_to_WB loads raw word at index (don't-care to WB, but deterministic).
REQ-014 Load latency: value at WB one cycle after instruction sits in Mem; a store followed next cycle by a load to the same address returns the stored value.
REQ-015 Tnew decrement: Tnew_WAddr_Mem = Tnew_WAddr_EX_to_Mem - 1 if >0, else 0 (saturating); same value registered to WB.
REQ-016 All other Mem_to_WB fields copy their EX_to_Mem inputs each cycle; no stall or flush input.
REQ-017 Stores never write when InstrType has no store bit set; exactly one store op acts per cycle.

Reset
REQ-018 On reset==0 edge: PC_Mem_to_WB=32'h0000_3000, InstrType_Mem_to_WB=sll encoding (nop), RegWriteAddr=0, ALUOut=0, DMReadData=0, Tnew=0.
REQ-019 On reset==0 edge all 1024 memory words clear to 0; reset overrides any concurrent store.
REQ-020 Combinational outputs follow inputs regardless of reset.

Structure
REQ-021 InstrType bit indices for lw/lh/lhu/lb/lbu/sw/sh/sb and the sll nop encoding live in shared CPU_Param.
REQ-022 One sub-module dm_byte_ctrl: computes write byte enables, merged write word and extended load value from op, addr[1:0], data.
REQ-023 Memory depth is a parameter (default 1024) in CPU_Param.

Verification
REQ-024 sw 0x12345678 to 0x0000_0010, next cycle lw 0x10 -> DMReadData_Mem_to_WB=0x12345678.
REQ-025 After REQ-024, sb 0xAB to 0x11, then lb 0x11 -> 0xFFFF_FFAB; lbu 0x11 -> 0x0000_00AB; lw 0x10 -> 0x1234AB78.
REQ-026 sh 0x8001 to 0x22, lh 0x22 -> 0xFFFF_8001, lhu 0x20 -> low half unchanged zero-extended.
REQ-027 sw with RAddr1=5, WB writing $5=0xDEADBEEF, Tnew_WB=0 -> memory gets 0xDEADBEEF; same with RAddr1=0 -> DMWriteData_EX_to_Mem stored.
REQ-028 Tnew_EX_to_Mem 2 -> Tnew_Mem 1; 0 -> 0; reset==0 during a sw -> word stays 0, outputs at REQ-018 values.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared CPU parameters: instruction-type bit indices, nop encoding,
// data-memory depth and access-op decoding for the Mem stage.
package CPU_Param;

  localparam int unsigned INSTR_W  = 60;
  localparam int unsigned DM_DEPTH = 1024;

  localparam int unsigned IT_SLL = 0;
  localparam int unsigned IT_LW  = 30;
  localparam int unsigned IT_LH  = 31;
  localparam int unsigned IT_LHU = 32;
  localparam int unsigned IT_LB  = 33;
  localparam int unsigned IT_LBU = 34;
  localparam int unsigned IT_SW  = 35;
  localparam int unsigned IT_SH  = 36;
  localparam int unsigned IT_SB  = 37;

  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(1) << IT_SLL;
  localparam logic [31:0]        PC_RESET  = 32'h0000_3000;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_WORD,
    OP_HALF,
    OP_HALFU,
    OP_BYTE,
    OP_BYTEU
  } dm_op_t;

  // Fixed priority guarantees a single store op even on a malformed vector.
  function automatic dm_op_t store_op(input logic [INSTR_W-1:0] it);
    if (it[IT_SW])      return OP_WORD;
    else if (it[IT_SH]) return OP_HALF;
    else if (it[IT_SB]) return OP_BYTE;
    else                return OP_NONE;
  endfunction

  function automatic dm_op_t load_op(input logic [INSTR_W-1:0] it);
    if (it[IT_LW])       return OP_WORD;
    else if (it[IT_LH])  return OP_HALF;
    else if (it[IT_LHU]) return OP_HALFU;
    else if (it[IT_LB])  return OP_BYTE;
    else if (it[IT_LBU]) return OP_BYTEU;
    else                 return OP_NONE;
  endfunction

endpackage

// File: rtl/mem_stage_dm_byte_ctrl.sv
// Data-memory lane control: byte enables and merged word for stores,
// lane select plus sign/zero extension for loads.
module dm_byte_ctrl
  import CPU_Param::*;
(
  input  dm_op_t      st_op,
  input  dm_op_t      ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata
);

  logic [31:0] wrep;
  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    be   = '0;
    wrep = wdata;
    case (st_op)
      OP_WORD: be = 4'hF;
      OP_HALF: begin
        be   = addr[1] ? 4'hC : 4'h3;
        wrep = {2{wdata[15:0]}};
      end
      OP_BYTE: begin
        be   = 4'b0001 << addr;
        wrep = {4{wdata[7:0]}};
      end
      default: be = '0;
    endcase

    // Data is replicated across lanes so the enables alone pick the target.
    wword = rword;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) wword[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  always_comb begin
    half     = addr[1] ? rword[31:16] : rword[15:0];
    byte_sel = rword[8*addr +: 8];
    case (ld_op)
      OP_HALF:  ldata = {{16{half[15]}}, half};
      OP_HALFU: ldata = {16'h0000, half};
      OP_BYTE:  ldata = {{24{byte_sel[7]}}, byte_sel};
      OP_BYTEU: ldata = {24'h000000, byte_sel};
      default:  ldata = rword;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Mem pipeline stage: data memory with byte/half/word access, store-data
// forwarding from WB, Tnew decrement and the Mem/WB pipeline register.
module mem_stage
  import CPU_Param::*;
#(
  parameter int unsigned DEPTH = DM_DEPTH
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        PC_EX_to_Mem,
  input  logic [4:0]         RAddr1_EX_to_Mem,
  input  logic [4:0]         RegWriteAddr_EX_to_Mem,
  input  logic [INSTR_W-1:0] InstrType_EX_to_Mem,
  input  logic [31:0]        ALUOut_EX_to_Mem,
  input  logic [31:0]        DMWriteData_EX_to_Mem,
  input  logic [2:0]         Tnew_WAddr_EX_to_Mem,
  input  logic [4:0]         RegWriteAddr_WB,
  input  logic [31:0]        RegWriteData_WB,
  input  logic [2:0]         Tnew_WAddr_WB,
  output logic [31:0]        PC_Mem_to_WB,
  output logic [4:0]         RegWriteAddr_Mem_to_WB,
  output logic [INSTR_W-1:0] InstrType_Mem_to_WB,
  output logic [31:0]        ALUOut_Mem_to_WB,
  output logic [31:0]        DMReadData_Mem_to_WB,
  output logic [2:0]         Tnew_WAddr_Mem_to_WB,
  output logic [4:0]         RegWriteAddr_Mem,
  output logic [2:0]         Tnew_WAddr_Mem,
  output logic [31:0]        ForwardData_Mem
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [31:0]   store_data;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   ldata;

  assign idx   = ALUOut_EX_to_Mem[AW+1:2];
  assign rword = mem[idx];

  always_comb begin
    store_data = DMWriteData_EX_to_Mem;
    if (RAddr1_EX_to_Mem != 5'd0 && RAddr1_EX_to_Mem == RegWriteAddr_WB &&
        Tnew_WAddr_WB == 3'd0)
      store_data = RegWriteData_WB;
  end

  always_comb begin
    RegWriteAddr_Mem = RegWriteAddr_EX_to_Mem;
    ForwardData_Mem  = ALUOut_EX_to_Mem;
    Tnew_WAddr_Mem   = (Tnew_WAddr_EX_to_Mem != 3'd0) ? Tnew_WAddr_EX_to_Mem - 3'd1 : 3'd0;
  end

  dm_byte_ctrl u_dm_byte_ctrl (
    .st_op (store_op(InstrType_EX_to_Mem)),
    .ld_op (load_op(InstrType_EX_to_Mem)),
    .addr  (ALUOut_EX_to_Mem[1:0]),
    .wdata (store_data),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .ldata (ldata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (|be) begin
      mem[idx] <= wword;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      PC_Mem_to_WB           <= PC_RESET;
      RegWriteAddr_Mem_to_WB <= '0;
      InstrType_Mem_to_WB    <= NOP_INSTR;
      ALUOut_Mem_to_WB       <= '0;
      DMReadData_Mem_to_WB   <= '0;
      Tnew_WAddr_Mem_to_WB   <= '0;
    end else begin
      PC_Mem_to_WB           <= PC_EX_to_Mem;
      RegWriteAddr_Mem_to_WB <= RegWriteAddr_EX_to_Mem;
      InstrType_Mem_to_WB    <= InstrType_EX_to_Mem;
      ALUOut_Mem_to_WB       <= ALUOut_EX_to_Mem;
      DMReadData_Mem_to_WB   <= ldata;
      Tnew_WAddr_Mem_to_WB   <= Tnew_WAddr_Mem;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  import CPU_Param::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        PC_EX_to_Mem;
  logic [4:0]         RAddr1_EX_to_Mem;
  logic [4:0]         RegWriteAddr_EX_to_Mem;
  logic [INSTR_W-1:0] InstrType_EX_to_Mem;
  logic [31:0]        ALUOut_EX_to_Mem;
  logic [31:0]        DMWriteData_EX_to_Mem;
  logic [2:0]         Tnew_WAddr_EX_to_Mem;
  logic [4:0]         RegWriteAddr_WB;
  logic [31:0]        RegWriteData_WB;
  logic [2:0]         Tnew_WAddr_WB;
  logic [31:0]        PC_Mem_to_WB;
  logic [4:0]         RegWriteAddr_Mem_to_WB;
  logic [INSTR_W-1:0] InstrType_Mem_to_WB;
  logic [31:0]        ALUOut_Mem_to_WB;
  logic [31:0]        DMReadData_Mem_to_WB;
  logic [2:0]         Tnew_WAddr_Mem_to_WB;
  logic [4:0]         RegWriteAddr_Mem;
  logic [2:0]         Tnew_WAddr_Mem;
  logic [31:0]        ForwardData_Mem;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pc = 32'h0000_4000;

  localparam logic [INSTR_W-1:0] I_LW  = INSTR_W'(1) << IT_LW;
  localparam logic [INSTR_W-1:0] I_LH  = INSTR_W'(1) << IT_LH;
  localparam logic [INSTR_W-1:0] I_LHU = INSTR_W'(1) << IT_LHU;
  localparam logic [INSTR_W-1:0] I_LB  = INSTR_W'(1) << IT_LB;
  localparam logic [INSTR_W-1:0] I_LBU = INSTR_W'(1) << IT_LBU;
  localparam logic [INSTR_W-1:0] I_SW  = INSTR_W'(1) << IT_SW;
  localparam logic [INSTR_W-1:0] I_SH  = INSTR_W'(1) << IT_SH;
  localparam logic [INSTR_W-1:0] I_SB  = INSTR_W'(1) << IT_SB;
  localparam logic [INSTR_W-1:0] I_ALU = INSTR_W'(1) << 5;

  mem_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .PC_EX_to_Mem           (PC_EX_to_Mem),
    .RAddr1_EX_to_Mem       (RAddr1_EX_to_Mem),
    .RegWriteAddr_EX_to_Mem (RegWriteAddr_EX_to_Mem),
    .InstrType_EX_to_Mem    (InstrType_EX_to_Mem),
    .ALUOut_EX_to_Mem       (ALUOut_EX_to_Mem),
    .DMWriteData_EX_to_Mem  (DMWriteData_EX_to_Mem),
    .Tnew_WAddr_EX_to_Mem   (Tnew_WAddr_EX_to_Mem),
    .RegWriteAddr_WB        (RegWriteAddr_WB),
    .RegWriteData_WB        (RegWriteData_WB),
    .Tnew_WAddr_WB          (Tnew_WAddr_WB),
    .PC_Mem_to_WB           (PC_Mem_to_WB),
    .RegWriteAddr_Mem_to_WB (RegWriteAddr_Mem_to_WB),
    .InstrType_Mem_to_WB    (InstrType_Mem_to_WB),
    .ALUOut_Mem_to_WB       (ALUOut_Mem_to_WB),
    .DMReadData_Mem_to_WB   (DMReadData_Mem_to_WB),
    .Tnew_WAddr_Mem_to_WB   (Tnew_WAddr_Mem_to_WB),
    .RegWriteAddr_Mem       (RegWriteAddr_Mem),
    .Tnew_WAddr_Mem         (Tnew_WAddr_Mem),
    .ForwardData_Mem        (ForwardData_Mem)
  );

  always #5 clk = ~clk;

  // Present one instruction at the Mem inputs; WB forwarding path idle.
  task automatic drive(input logic [INSTR_W-1:0] it, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] raddr1);
    pc                     = pc + 32'd4;
    PC_EX_to_Mem           = pc;
    InstrType_EX_to_Mem    = it;
    ALUOut_EX_to_Mem       = addr;
    DMWriteData_EX_to_Mem  = wdata;
    RAddr1_EX_to_Mem       = raddr1;
    RegWriteAddr_EX_to_Mem = 5'd7;
    Tnew_WAddr_EX_to_Mem   = 3'd0;
    RegWriteAddr_WB        = 5'd0;
    RegWriteData_WB        = 32'h0;
    Tnew_WAddr_WB          = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(I_SW, 32'h0000_0050, 32'hCAFE_F00D, 5'd0);
    Tnew_WAddr_EX_to_Mem = 3'd2;
    #1;
    n_cmp++;
    if (Tnew_WAddr_Mem !== 3'd1) begin
      n_err++; $display("FAIL reset_comb_tnew: got %0d want 1", Tnew_WAddr_Mem);
    end
    n_cmp++;
    if (ForwardData_Mem !== 32'h0000_0050) begin
      n_err++; $display("FAIL reset_comb_fwd: got %h want 00000050", ForwardData_Mem);
    end
    step(); step();
    n_cmp++;
    if (PC_Mem_to_WB !== 32'h0000_3000) begin
      n_err++; $display("FAIL reset_pc: got %h want 00003000", PC_Mem_to_WB);
    end
    n_cmp++;
    if (InstrType_Mem_to_WB !== NOP_INSTR) begin
      n_err++; $display("FAIL reset_instr: got %h want %h", InstrType_Mem_to_WB, NOP_INSTR);
    end
    n_cmp++;
    if ({RegWriteAddr_Mem_to_WB, ALUOut_Mem_to_WB, DMReadData_Mem_to_WB, Tnew_WAddr_Mem_to_WB} !== '0) begin
      n_err++;
      $display("FAIL reset_zero: got waddr=%h alu=%h rd=%h tnew=%h want all 0",
               RegWriteAddr_Mem_to_WB, ALUOut_Mem_to_WB, DMReadData_Mem_to_WB, Tnew_WAddr_Mem_to_WB);
    end
    reset = 1'b1;
    drive(I_LW, 32'h0000_0050, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h0) begin
      n_err++; $display("FAIL reset_store_blocked: got %h want 00000000", DMReadData_Mem_to_WB);
    end
  endtask

  task automatic test_sw_lw();
    drive(I_SW, 32'h0000_0010, 32'h1234_5678, 5'd0);
    step();
    drive(I_LW, 32'h0000_0010, 32'h0, 5'd0);
    RegWriteAddr_EX_to_Mem = 5'd9;
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h1234_5678) begin
      n_err++; $display("FAIL sw_lw: got %h want 12345678", DMReadData_Mem_to_WB);
    end
    n_cmp++;
    if (PC_Mem_to_WB !== pc || RegWriteAddr_Mem_to_WB !== 5'd9 ||
        ALUOut_Mem_to_WB !== 32'h10 || InstrType_Mem_to_WB !== I_LW) begin
      n_err++;
      $display("FAIL pass_through: got pc=%h wa=%0d alu=%h want pc=%h wa=9 alu=10 (lw)",
               PC_Mem_to_WB, RegWriteAddr_Mem_to_WB, ALUOut_Mem_to_WB, pc);
    end
  endtask

  task automatic test_byte();
    drive(I_SB, 32'h0000_0011, 32'h55AA_CCAB, 5'd0);
    step();
    drive(I_LB, 32'h0000_0011, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'hFFFF_FFAB) begin
      n_err++; $display("FAIL lb: got %h want ffffffab", DMReadData_Mem_to_WB);
    end
    drive(I_LBU, 32'h0000_0011, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h0000_00AB) begin
      n_err++; $display("FAIL lbu: got %h want 000000ab", DMReadData_Mem_to_WB);
    end
    drive(I_LW, 32'h0000_0010, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h1234_AB78) begin
      n_err++; $display("FAIL sb_merge: got %h want 1234ab78", DMReadData_Mem_to_WB);
    end
    drive(I_LBU, 32'h0000_0013, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h0000_0012) begin
      n_err++; $display("FAIL lbu_lane3: got %h want 00000012", DMReadData_Mem_to_WB);
    end
  endtask

  task automatic test_half();
    drive(I_SW, 32'h0000_0020, 32'h0000_7FFE, 5'd0);
    step();
    drive(I_SH, 32'h0000_0022, 32'h1234_8001, 5'd0);
    step();
    drive(I_LH, 32'h0000_0022, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'hFFFF_8001) begin
      n_err++; $display("FAIL lh_hi: got %h want ffff8001", DMReadData_Mem_to_WB);
    end
    drive(I_LHU, 32'h0000_0020, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h0000_7FFE) begin
      n_err++; $display("FAIL lhu_lo: got %h want 00007ffe", DMReadData_Mem_to_WB);
    end
    drive(I_LH, 32'h0000_0023, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'hFFFF_8001) begin
      n_err++; $display("FAIL lh_addr0_ignored: got %h want ffff8001", DMReadData_Mem_to_WB);
    end
    drive(I_LW, 32'h0000_0020, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h8001_7FFE) begin
      n_err++; $display("FAIL sh_merge: got %h want 80017ffe", DMReadData_Mem_to_WB);
    end
  endtask

  task automatic test_forward();
    drive(I_SW, 32'h0000_0030, 32'h1111_1111, 5'd5);
    RegWriteAddr_WB = 5'd5; RegWriteData_WB = 32'hDEAD_BEEF; Tnew_WAddr_WB = 3'd0;
    step();
    drive(I_SW, 32'h0000_0034, 32'h2222_2222, 5'd0);
    RegWriteAddr_WB = 5'd0; RegWriteData_WB = 32'hDEAD_BEEF; Tnew_WAddr_WB = 3'd0;
    step();
    drive(I_SW, 32'h0000_0038, 32'h3333_3333, 5'd5);
    RegWriteAddr_WB = 5'd5; RegWriteData_WB = 32'hDEAD_BEEF; Tnew_WAddr_WB = 3'd1;
    step();
    drive(I_LW, 32'h0000_0030, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL fwd_match: got %h want deadbeef", DMReadData_Mem_to_WB);
    end
    drive(I_LW, 32'h0000_0034, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h2222_2222) begin
      n_err++; $display("FAIL fwd_r0: got %h want 22222222", DMReadData_Mem_to_WB);
    end
    drive(I_LW, 32'h0000_0038, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h3333_3333) begin
      n_err++; $display("FAIL fwd_tnew_busy: got %h want 33333333", DMReadData_Mem_to_WB);
    end
  endtask

  task automatic test_tnew();
    logic [2:0] tin [4] = '{3'd2, 3'd0, 3'd7, 3'd1};
    logic [2:0] tex [4] = '{3'd1, 3'd0, 3'd6, 3'd0};
    for (int i = 0; i < 4; i++) begin
      drive(I_ALU, 32'h0, 32'h0, 5'd0);
      Tnew_WAddr_EX_to_Mem = tin[i];
      #1;
      n_cmp++;
      if (Tnew_WAddr_Mem !== tex[i]) begin
        n_err++; $display("FAIL tnew_comb[%0d]: got %0d want %0d", i, Tnew_WAddr_Mem, tex[i]);
      end
      step();
      n_cmp++;
      if (Tnew_WAddr_Mem_to_WB !== tex[i]) begin
        n_err++; $display("FAIL tnew_reg[%0d]: got %0d want %0d", i, Tnew_WAddr_Mem_to_WB, tex[i]);
      end
    end
  endtask

  task automatic test_misc();
    drive(I_SW, 32'hFFFF_F040, 32'hA5A5_5A5A, 5'd0);
    step();
    drive(I_LW, 32'h0000_0040, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'hA5A5_5A5A) begin
      n_err++; $display("FAIL addr_high_ignored: got %h want a5a55a5a", DMReadData_Mem_to_WB);
    end
    drive(I_SW, 32'h0000_0FFC, 32'h0BAD_F00D, 5'd0);
    step();
    drive(I_LW, 32'h0000_0FFC, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL top_word: got %h want 0badf00d", DMReadData_Mem_to_WB);
    end
    drive(I_ALU, 32'h0000_0010, 32'hFFFF_FFFF, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h1234_AB78) begin
      n_err++; $display("FAIL nonload_raw: got %h want 1234ab78", DMReadData_Mem_to_WB);
    end
    drive(I_LW, 32'h0000_0010, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h1234_AB78) begin
      n_err++; $display("FAIL no_store_write: got %h want 1234ab78", DMReadData_Mem_to_WB);
    end
  endtask

  task automatic test_reset_during_store();
    reset = 1'b0;
    drive(I_SW, 32'h0000_0060, 32'h7777_7777, 5'd0);
    step();
    n_cmp++;
    if (PC_Mem_to_WB !== 32'h0000_3000 || InstrType_Mem_to_WB !== NOP_INSTR ||
        DMReadData_Mem_to_WB !== 32'h0 || ALUOut_Mem_to_WB !== 32'h0) begin
      n_err++;
      $display("FAIL reset2_outputs: got pc=%h rd=%h alu=%h want 00003000/0/0",
               PC_Mem_to_WB, DMReadData_Mem_to_WB, ALUOut_Mem_to_WB);
    end
    reset = 1'b1;
    drive(I_LW, 32'h0000_0060, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h0) begin
      n_err++; $display("FAIL reset2_store_blocked: got %h want 00000000", DMReadData_Mem_to_WB);
    end
    drive(I_LW, 32'h0000_0010, 32'h0, 5'd0);
    step();
    n_cmp++;
    if (DMReadData_Mem_to_WB !== 32'h0) begin
      n_err++; $display("FAIL reset2_mem_clear: got %h want 00000000", DMReadData_Mem_to_WB);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_forward();
    test_tnew();
    test_misc();
    test_reset_during_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
